// File: rtl/gpr_file_mp.sv
// Multi-read-port register file with an in-flight-write scoreboard and a
// registered operand stage between decode and execute. Issue stalls on
// RAW/WAW hazards; writeback writes the array, clears the scoreboard and,
// when BYPASS=1, forwards its data and its scoreboard clear to the issue in
// the same cycle.
module gpr_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREG   = 16,
   parameter int NRP    = 2,
   parameter int BYPASS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic [NRP*5-1:0]     issue_rs,
   input  logic [NRP-1:0]       issue_rs_en,
   input  logic [4:0]           issue_rd,
   input  logic                 issue_rd_we,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NRP*XLEN-1:0]  out_src,
   input  logic                 wb_valid,
   input  logic                 wb_we,
   input  logic [4:0]           wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   output logic [NREG-1:0]      busy_vec
);

   localparam int IW = $clog2(NREG);

   logic [XLEN-1:0]     regs_reg [NREG];
   logic [NREG-1:0]     busy_reg;
   logic [NREG-1:0]     busy_next;
   logic                out_valid_reg;
   logic [NRP*XLEN-1:0] out_src_reg;
   logic [NRP*XLEN-1:0] src_next;

   logic                wb_fire;
   logic                issue_fire;
   logic                waw;
   logic [NRP-1:0]      raw_vec;
   logic [31:0]         wb_mask;
   logic [31:0]         iss_mask;
   logic [31:0]         busy32;
   logic [31:0]         ebusy32;

   // Index is a real, writable register: in range and not x0.
   function automatic logic legal(input logic [4:0] idx);
      return (idx != 5'd0) && ({1'b0, idx} < 6'(NREG));
   endfunction

   assign wb_fire = wb_valid & wb_we & legal(wb_rd);
   assign wb_mask = wb_fire ? (32'd1 << wb_rd) : 32'd0;

   // Scoreboard widened to 32 entries so any 5-bit index looks up cleanly;
   // out-of-range entries are constant zero and never stall.
   assign busy32  = 32'(busy_reg);
   assign ebusy32 = (BYPASS != 0) ? (busy32 & ~wb_mask) : busy32;

   assign waw         = issue_rd_we & ebusy32[issue_rd];
   assign issue_ready = ~flush & ~(|raw_vec) & ~waw & (~out_valid_reg | out_ready);
   assign issue_fire  = issue_valid & issue_ready;
   assign iss_mask    = (issue_fire & issue_rd_we & legal(issue_rd)) ?
                        (32'd1 << issue_rd) : 32'd0;

   genvar gi;
   generate
      for (gi = 0; gi < NRP; gi++) begin : g_port
         logic [4:0]      rs;
         logic [XLEN-1:0] rdata;

         assign rs          = issue_rs[5*gi +: 5];
         assign raw_vec[gi] = issue_rs_en[gi] & ebusy32[rs];

         // Operand select: unused port -> 0, forwarded writeback, array, or 0 when out of range.
         always_comb begin
            rdata = '0;
            if (!issue_rs_en[gi]) begin
               rdata = '0;
            end else if ((BYPASS != 0) && wb_fire && (wb_rd == rs)) begin
               rdata = wb_data;
            end else if (legal(rs)) begin
               rdata = regs_reg[rs[IW-1:0]];
            end
         end

         assign src_next[XLEN*gi +: XLEN] = rdata;
      end
   endgenerate

   // Scoreboard update: writeback clears first, so a same-cycle issue set wins.
   always_comb begin
      busy_next = busy_reg;
      if (flush) begin
         busy_next = '0;
      end else begin
         busy_next = NREG'((busy32 & ~wb_mask) | iss_mask);
      end
   end

   // Register array; writeback lands even in a flush cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wb_fire) begin
         regs_reg[wb_rd[IW-1:0]] <= wb_data;
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   // Operand output stage: load on issue, drain on out_ready, hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_src_reg   <= '0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
         out_src_reg   <= '0;
      end else if (issue_fire) begin
         out_valid_reg <= 1'b1;
         out_src_reg   <= src_next;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_src   = out_src_reg;
   assign busy_vec  = busy_reg;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Testbench for gpr_file_mp: directed scenarios plus a randomized run, all
// checked against a behavioural model of the register file and scoreboard.
module tb_gpr_file_mp;

   localparam int XLEN   = 32;
   localparam int NREG   = 16;
   localparam int NRP    = 2;
   localparam int BYPASS = 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                flush;
   logic                issue_valid;
   logic                issue_ready;
   logic [NRP*5-1:0]    issue_rs;
   logic [NRP-1:0]      issue_rs_en;
   logic [4:0]          issue_rd;
   logic                issue_rd_we;
   logic                out_valid;
   logic                out_ready;
   logic [NRP*XLEN-1:0] out_src;
   logic                wb_valid;
   logic                wb_we;
   logic [4:0]          wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic [NREG-1:0]     busy_vec;

   int n_cmp = 0;
   int n_bad = 0;

   gpr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(BYPASS)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs(issue_rs), .issue_rs_en(issue_rs_en),
      .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
      .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [XLEN-1:0] m_reg [32];
   bit              m_busy [32];
   bit              m_ov;
   logic [XLEN-1:0] m_src [NRP];

   function automatic bit m_legal(int idx);
      return (idx != 0) && (idx < NREG);
   endfunction

   function automatic int rs_of(int k);
      logic [4:0] r;
      r = issue_rs[5*k +: 5];
      return int'(r);
   endfunction

   function automatic bit m_wbf();
      return wb_valid && wb_we && m_legal(int'(wb_rd));
   endfunction

   function automatic bit m_ebusy(int i);
      return m_busy[i] && !(BYPASS != 0 && m_wbf() && int'(wb_rd) == i);
   endfunction

   function automatic bit m_ready();
      if (flush) return 1'b0;
      for (int k = 0; k < NRP; k++)
         if (issue_rs_en[k] && m_ebusy(rs_of(k))) return 1'b0;
      if (issue_rd_we && m_ebusy(int'(issue_rd))) return 1'b0;
      if (m_ov && !out_ready) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NRP*XLEN-1:0] m_pack();
      logic [NRP*XLEN-1:0] v;
      for (int k = 0; k < NRP; k++) v[XLEN*k +: XLEN] = m_src[k];
      return v;
   endfunction

   function automatic logic [NREG-1:0] m_busyv();
      logic [NREG-1:0] v;
      for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      m_ov = 1'b0;
      for (int k = 0; k < NRP; k++) m_src[k] = '0;
   endtask

   // Advance one clock edge and apply the same edge to the model; returns at posedge+1.
   task automatic tick();
      bit              rdy, wbf, fire;
      logic [XLEN-1:0] nsrc [NRP];
      int              r;
      rdy  = m_ready();
      wbf  = m_wbf();
      fire = issue_valid && rdy;
      for (int k = 0; k < NRP; k++) begin
         r = rs_of(k);
         if (!issue_rs_en[k])                           nsrc[k] = '0;
         else if (BYPASS != 0 && wbf && int'(wb_rd) == r) nsrc[k] = wb_data;
         else if (m_legal(r))                           nsrc[k] = m_reg[r];
         else                                           nsrc[k] = '0;
      end
      @(posedge clk);
      if (wbf) begin
         m_reg[wb_rd]  = wb_data;
         m_busy[wb_rd] = 1'b0;
      end
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_ov = 1'b0;
         for (int k = 0; k < NRP; k++) m_src[k] = '0;
      end else if (fire) begin
         for (int k = 0; k < NRP; k++) m_src[k] = nsrc[k];
         m_ov = 1'b1;
         if (issue_rd_we && m_legal(int'(issue_rd))) m_busy[issue_rd] = 1'b1;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; issue_valid = 0; issue_rs = '0; issue_rs_en = '0;
      issue_rd = '0; issue_rd_we = 0; out_ready = 1;
      wb_valid = 0; wb_we = 0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic set_issue(input logic [4:0] rs0, input logic [4:0] rs1,
                            input logic [1:0] en, input logic [4:0] rd, input logic we);
      issue_valid = 1; issue_rs = {rs1, rs0}; issue_rs_en = en;
      issue_rd = rd; issue_rd_we = we;
   endtask

   task automatic set_wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
      wb_valid = 1; wb_we = 1; wb_rd = rd; wb_data = d;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_src !== '0) begin n_bad++; $display("FAIL reset_out_src: got %h expected 0", out_src); end
      n_cmp++; if (busy_vec !== '0) begin n_bad++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
      rst = 0;
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
      $display("reset: done");
   endtask

   task automatic test_basic();
      set_wb(5'd5, 32'h1234_5678);
      #1; tick();
      idle_inputs();
      set_issue(5'd5, 5'd0, 2'b11, 5'd0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b expected 1", issue_ready); end
      tick();
      idle_inputs();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
      n_cmp++; if (out_src !== {32'h0, 32'h1234_5678}) begin n_bad++; $display("FAIL basic_out_src: got %h expected %h", out_src, {32'h0, 32'h1234_5678}); end
      $display("basic: out_src=%h", out_src);
   endtask

   task automatic test_raw();
      set_issue(5'd0, 5'd0, 2'b00, 5'd7, 1);
      #1; tick();
      n_cmp++; if (busy_vec[7] !== 1'b1) begin n_bad++; $display("FAIL raw_busy_set: got %b expected 1", busy_vec[7]); end
      set_issue(5'd7, 5'd0, 2'b01, 5'd0, 0);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall: got %b expected 0", issue_ready); end
         tick();
      end
      set_wb(5'd7, 32'h0000_00AA);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL raw_release: got %b expected 1", issue_ready); end
      tick();
      idle_inputs();
      n_cmp++; if (out_src[31:0] !== 32'hAA) begin n_bad++; $display("FAIL raw_bypass_data: got %h expected 000000aa", out_src[31:0]); end
      n_cmp++; if (busy_vec[7] !== 1'b0) begin n_bad++; $display("FAIL raw_busy_clear: got %b expected 0", busy_vec[7]); end
      $display("raw: out_src0=%h busy=%h", out_src[31:0], busy_vec);
   endtask

   task automatic test_backpressure();
      logic [NRP*XLEN-1:0] held;
      #1; tick();                      // drain
      out_ready = 0;
      set_issue(5'd5, 5'd0, 2'b01, 5'd0, 0);
      #1; tick();
      held = out_src;
      n_cmp++; if (held !== {32'h0, 32'h1234_5678}) begin n_bad++; $display("FAIL bp_load: got %h expected %h", held, {32'h0, 32'h1234_5678}); end
      set_issue(5'd7, 5'd7, 2'b11, 5'd0, 0);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b expected 0", issue_ready); end
         tick();
         n_cmp++; if (out_src !== held || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %h/%b expected %h/1", out_src, out_valid, held); end
      end
      out_ready = 1;
      set_issue(5'd5, 5'd5, 2'b11, 5'd0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b expected 1", issue_ready); end
      tick();
      idle_inputs();
      n_cmp++; if (out_src !== {32'h1234_5678, 32'h1234_5678}) begin n_bad++; $display("FAIL bp_new: got %h expected %h", out_src, {32'h1234_5678, 32'h1234_5678}); end
      $display("backpressure: out_src=%h", out_src);
   endtask

   task automatic test_setclear();
      set_issue(5'd0, 5'd0, 2'b00, 5'd3, 1);
      #1; tick();
      set_wb(5'd3, 32'h0000_CAFE);
      set_issue(5'd0, 5'd0, 2'b00, 5'd3, 1);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL sc_ready: got %b expected 1", issue_ready); end
      tick();
      idle_inputs();
      n_cmp++; if (busy_vec[3] !== 1'b1) begin n_bad++; $display("FAIL sc_set_wins: got %b expected 1", busy_vec[3]); end
      flush = 1;
      #1; tick();
      idle_inputs();
      set_issue(5'd3, 5'd0, 2'b01, 5'd0, 0);
      #1; tick();
      idle_inputs();
      n_cmp++; if (out_src[31:0] !== 32'hCAFE) begin n_bad++; $display("FAIL sc_array: got %h expected 0000cafe", out_src[31:0]); end
      $display("setclear: x3=%h", out_src[31:0]);
   endtask

   task automatic test_flush();
      set_issue(5'd0, 5'd0, 2'b00, 5'd2, 1);
      #1; tick();
      set_issue(5'd0, 5'd0, 2'b00, 5'd9, 1);
      #1; tick();
      n_cmp++; if (busy_vec !== 16'h0204 || out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got %h/%b expected 0204/1", busy_vec, out_valid); end
      flush = 1;
      set_issue(5'd5, 5'd0, 2'b01, 5'd4, 1);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b expected 0", issue_ready); end
      tick();
      idle_inputs();
      n_cmp++; if (busy_vec !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear: got %h/%b expected 0000/0", busy_vec, out_valid); end
      $display("flush: busy=%h out_valid=%b", busy_vec, out_valid);
   endtask

   task automatic test_boundary();
      set_wb(5'd20, 32'h0000_DEAD);
      set_issue(5'd20, 5'd0, 2'b01, 5'd20, 1);
      #1; tick();
      idle_inputs();
      n_cmp++; if (out_src[31:0] !== 32'h0 || busy_vec !== '0) begin n_bad++; $display("FAIL bnd_oor: got %h/%h expected 0/0", out_src[31:0], busy_vec); end
      set_wb(5'd0, 32'h0000_0055);
      #1; tick();
      idle_inputs();
      set_issue(5'd20, 5'd4, 2'b11, 5'd0, 0);
      #1; tick();
      idle_inputs();
      n_cmp++; if (out_src !== m_pack()) begin n_bad++; $display("FAIL bnd_alias: got %h expected %h", out_src, m_pack()); end
      set_issue(5'd0, 5'd0, 2'b01, 5'd0, 1);
      #1; tick();
      idle_inputs();
      n_cmp++; if (out_src[31:0] !== 32'h0 || busy_vec[0] !== 1'b0) begin n_bad++; $display("FAIL bnd_x0: got %h/%b expected 0/0", out_src[31:0], busy_vec[0]); end
      $display("boundary: out_src=%h busy=%h", out_src, busy_vec);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         flush       = ($urandom_range(0, 19) == 0);
         issue_valid = ($urandom_range(0, 9) < 7);
         issue_rs    = {5'($urandom_range(0, NREG + 3)), 5'($urandom_range(0, NREG + 3))};
         issue_rs_en = 2'($urandom);
         issue_rd    = 5'($urandom_range(0, NREG + 3));
         issue_rd_we = 1'($urandom);
         out_ready   = ($urandom_range(0, 3) != 0);
         wb_valid    = 1'($urandom);
         wb_we       = ($urandom_range(0, 4) != 0);
         wb_rd       = 5'($urandom_range(0, NREG + 3));
         wb_data     = $urandom;
         #1;
         n_cmp++; if (issue_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, issue_ready, m_ready()); end
         tick();
         n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, out_valid, m_ov); end
         n_cmp++; if (out_src !== m_pack()) begin n_bad++; $display("FAIL rnd_out_src c=%0d: got %h expected %h", c, out_src, m_pack()); end
         n_cmp++; if (busy_vec !== m_busyv()) begin n_bad++; $display("FAIL rnd_busy c=%0d: got %h expected %h", c, busy_vec, m_busyv()); end
      end
      idle_inputs();
      $display("random: 400 cycles");
   endtask

   task automatic test_async_reset();
      set_issue(5'd0, 5'd0, 2'b00, 5'd6, 1);
      #1; tick();
      idle_inputs();
      #2 rst = 1;
      #1;
      n_cmp++; if (busy_vec !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_clear: got %h/%b expected 0000/0", busy_vec, out_valid); end
      m_reset();
      @(posedge clk); #1;
      rst = 0;
      set_issue(5'd5, 5'd0, 2'b01, 5'd0, 0);
      #1; tick();
      idle_inputs();
      n_cmp++; if (out_src !== '0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_regs: got %h/%b expected 0/1", out_src, out_valid); end
      $display("async_reset: busy=%h", busy_vec);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_basic();
      test_raw();
      test_backpressure();
      test_setclear();
      test_flush();
      test_boundary();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
